multicycle_ctrl_fsm: RTL and testbench

//  Parametrised multicycle control unit for the 4-bit-opcode CPU datapath. Moore FSM that sequences

---
 rtl/ctrl_pkg.sv | 59 +++++
 rtl/multicycle_ctrl_fsm_if.sv | 38 +++
 rtl/ctrl_wait_timer.sv | 32 +++
 rtl/multicycle_ctrl_fsm.sv | 170 +++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle control unit: state codes, opcodes, ALU operations
// and datapath mux selects.
package ctrl_pkg;

  localparam logic [4:0] ST_FETCH   = 5'd0;
  localparam logic [4:0] ST_DECODE  = 5'd1;
  localparam logic [4:0] ST_RTYPE   = 5'd2;
  localparam logic [4:0] ST_RWRITE  = 5'd3;
  localparam logic [4:0] ST_ADDR    = 5'd4;
  localparam logic [4:0] ST_LWREAD  = 5'd5;
  localparam logic [4:0] ST_LWWB    = 5'd6;
  localparam logic [4:0] ST_SWWRITE = 5'd7;
  localparam logic [4:0] ST_IMM     = 5'd8;
  localparam logic [4:0] ST_IMMWB   = 5'd9;
  localparam logic [4:0] ST_JAL1    = 5'd10;
  localparam logic [4:0] ST_JAL2    = 5'd11;
  localparam logic [4:0] ST_JR      = 5'd12;
  localparam logic [4:0] ST_JUMP    = 5'd13;
  localparam logic [4:0] ST_BEQ     = 5'd14;
  localparam logic [4:0] ST_BNE     = 5'd15;
  localparam logic [4:0] ST_IN      = 5'd16;
  localparam logic [4:0] ST_OUT     = 5'd17;
  localparam logic [4:0] ST_TRAP    = 5'd18;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_LW    = 4'd2;
  localparam logic [3:0] OP_SW    = 4'd3;
  localparam logic [3:0] OP_ORI   = 4'd4;
  localparam logic [3:0] OP_ANDI  = 4'd5;
  localparam logic [3:0] OP_BEQ   = 4'd7;
  localparam logic [3:0] OP_BNE   = 4'd8;
  localparam logic [3:0] OP_JUMP  = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_JR    = 4'd11;
  localparam logic [3:0] OP_IO    = 4'd12;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;

  localparam logic [1:0] SRCB_REG   = 2'd0;
  localparam logic [1:0] SRCB_TWO   = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] PCSRC_ALU  = 2'd0;
  localparam logic [1:0] PCSRC_JUMP = 2'd1;
  localparam logic [1:0] M2R_MDR    = 2'd0;
  localparam logic [1:0] M2R_ALU    = 2'd1;
  localparam logic [1:0] M2R_IN     = 2'd2;
  localparam logic [1:0] RDST_RD    = 2'd1;
  localparam logic [1:0] RDST_RA    = 2'd3;

  // States that wait on MemReady and are therefore subject to the timeout.
  function automatic logic isMemState(input logic [4:0] s);
    return (s == ST_FETCH) || (s == ST_LWREAD) || (s == ST_SWWRITE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control-unit bus: IR fields and handshake inputs toward the FSM, datapath controls back out.
interface multicycle_ctrl_fsm_if #(
  parameter int OPW    = 4,
  parameter int FNW    = 3,
  parameter int ALUOPW = 3
);
  logic [OPW-1:0]    Opcode;
  logic [FNW-1:0]    funk;
  logic              MemReady;
  logic              InValid;
  logic              OutReady;
  logic [ALUOPW-1:0] ALUOp;
  logic              SrcA;
  logic [1:0]        SrcB;
  logic [1:0]        PCSrc;
  logic [1:0]        MemtoReg;
  logic [1:0]        RegDest;
  logic              RegWrite, MemRead, MemWrite, MemSrc, IRWrite, PCWrite;
  logic              BranchCond, OutputWrite, InAck, MemErr, IllegalOp;
  logic [4:0]        current_state;
  logic [4:0]        next_state;

  modport master (
    input  Opcode, funk, MemReady, InValid, OutReady,
    output ALUOp, SrcA, SrcB, PCSrc, MemtoReg, RegDest,
    output RegWrite, MemRead, MemWrite, MemSrc, IRWrite, PCWrite,
    output BranchCond, OutputWrite, InAck, MemErr, IllegalOp,
    output current_state, next_state
  );

  modport slave (
    output Opcode, funk, MemReady, InValid, OutReady,
    input  ALUOp, SrcA, SrcB, PCSrc, MemtoReg, RegDest,
    input  RegWrite, MemRead, MemWrite, MemSrc, IRWrite, PCWrite,
    input  BranchCond, OutputWrite, InAck, MemErr, IllegalOp,
    input  current_state, next_state
  );
endinterface

// File: rtl/ctrl_wait_timer.sv
// Memory-wait counter: counts stalled cycles in a memory state and flags the timeout cycle.
module ctrl_wait_timer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic CLK,
  input  logic Reset,
  input  logic stateChange,
  input  logic waiting,
  output logic timeout
);
  localparam int CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX);

  logic [CW-1:0] countReg;

  generate
    if (MEM_WAIT_MAX > 0) begin : gLimit
      assign timeout = waiting && (countReg == CW'(MEM_WAIT_MAX - 1));
    end else begin : gForever
      assign timeout = 1'b0;
    end
  endgenerate

  // A timeout in FETCH does not change state, so it must clear the count itself.
  always_ff @(posedge CLK) begin
    if (!Reset || stateChange || timeout) begin
      countReg <= '0;
    end else if (waiting && (countReg != '1)) begin
      countReg <= countReg + CW'(1);
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM for the 4-bit-opcode multicycle CPU.
// Define CTRL_ILLEGAL_TRAP_EN to trap on illegal opcodes; otherwise they execute as NOPs.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int OPW          = 4,
  parameter int FNW          = 3,
  parameter int ALUOPW       = 3,
  parameter int MEM_WAIT_MAX = 15
) (
  input logic                   CLK,
  input logic                   Reset,
  multicycle_ctrl_fsm_if.master bus
);
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic [4:0] ILLEGAL_NEXT = ST_TRAP;
`else
  localparam logic [4:0] ILLEGAL_NEXT = ST_FETCH;
`endif

  logic [4:0]        stateReg, stateNext;
  logic [OPW+3:0]    opExt;
  logic [3:0]        opLow;
  logic              opUpper, timeout, waiting, strobeEn;
  logic [ALUOPW-1:0] funkOp, aluOp;
  logic              srcA, memSrc, branchCond;
  logic [1:0]        srcB, pcSrc, memtoReg, regDest;
  logic              regWrite, memRead, memWrite, irWrite, pcWrite, outputWrite, inAck;

  assign opExt   = {{4{1'b0}}, bus.Opcode};
  assign opLow   = opExt[3:0];
  assign opUpper = |(opExt >> 4);

  genvar gi;
  generate
    for (gi = 0; gi < ALUOPW; gi++) begin : gFunk
      if (gi < FNW) begin : gBit
        assign funkOp[gi] = bus.funk[gi];
      end else begin : gZero
        assign funkOp[gi] = 1'b0;
      end
    end
  endgenerate

  assign waiting = isMemState(stateReg) && !bus.MemReady;

  ctrl_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) uWaitTimer (
    .CLK         (CLK),
    .Reset       (Reset),
    .stateChange (stateNext != stateReg),
    .waiting     (waiting),
    .timeout     (timeout)
  );

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      ST_FETCH:   if (bus.MemReady) stateNext = ST_DECODE;
      ST_DECODE: begin
        stateNext = ILLEGAL_NEXT;
        if (!opUpper) begin
          case (opLow)
            OP_RTYPE:                 stateNext = ST_RTYPE;
            OP_LW, OP_SW:             stateNext = ST_ADDR;
            OP_ADDI, OP_ORI, OP_ANDI: stateNext = ST_IMM;
            OP_BEQ:                   stateNext = ST_BEQ;
            OP_BNE:                   stateNext = ST_BNE;
            OP_JUMP:                  stateNext = ST_JUMP;
            OP_JAL:                   stateNext = ST_JAL1;
            OP_JR:                    stateNext = ST_JR;
            OP_IO:                    stateNext = (bus.funk == FNW'(1)) ? ST_IN : ST_OUT;
            default:                  stateNext = ILLEGAL_NEXT;
          endcase
        end
      end
      ST_RTYPE:   stateNext = ST_RWRITE;
      ST_ADDR:    stateNext = (opLow == OP_LW) ? ST_LWREAD : ST_SWWRITE;
      ST_LWREAD: begin
        if (bus.MemReady)  stateNext = ST_LWWB;
        else if (timeout)  stateNext = ST_FETCH;
      end
      ST_SWWRITE: if (bus.MemReady || timeout) stateNext = ST_FETCH;
      ST_IMM:     stateNext = ST_IMMWB;
      ST_JAL1:    stateNext = ST_JAL2;
      ST_IN:      if (bus.InValid) stateNext = ST_FETCH;
      ST_OUT:     if (bus.OutReady) stateNext = ST_FETCH;
      ST_TRAP:    stateNext = ST_TRAP;
      default:    stateNext = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) stateReg <= ST_FETCH;
    else        stateReg <= stateNext;
  end

  always_comb begin
    aluOp = '0; srcA = 1'b0; srcB = '0; pcSrc = '0; memtoReg = '0; regDest = '0;
    memSrc = 1'b0; branchCond = 1'b0; regWrite = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    irWrite = 1'b0; pcWrite = 1'b0; outputWrite = 1'b0; inAck = 1'b0;
    case (stateReg)
      ST_FETCH: begin
        memRead = 1'b1; srcB = SRCB_TWO; aluOp = ALUOPW'(ALU_ADD);
        irWrite = bus.MemReady; pcWrite = bus.MemReady;
      end
      ST_DECODE:  begin srcA = 1'b1; aluOp = ALUOPW'(ALU_ADD); end
      ST_RTYPE:   begin srcA = 1'b1; aluOp = funkOp; end
      ST_RWRITE, ST_IMMWB: begin regWrite = 1'b1; memtoReg = M2R_ALU; regDest = RDST_RD; end
      ST_ADDR:    begin srcA = 1'b1; srcB = SRCB_IMM; aluOp = ALUOPW'(ALU_ADD); end
      ST_LWREAD:  begin memRead = 1'b1; memSrc = 1'b1; end
      ST_LWWB:    begin regWrite = 1'b1; memtoReg = M2R_MDR; end
      ST_SWWRITE: begin memWrite = 1'b1; memSrc = 1'b1; end
      ST_IMM: begin
        srcA = 1'b1; srcB = SRCB_IMM;
        aluOp = (opLow == OP_ORI)  ? ALUOPW'(ALU_OR)  :
                (opLow == OP_ANDI) ? ALUOPW'(ALU_AND) : ALUOPW'(ALU_ADD);
      end
      ST_JAL1:    begin srcB = SRCB_TWO; aluOp = ALUOPW'(ALU_ADD); end
      ST_JAL2: begin
        regWrite = 1'b1; memtoReg = M2R_ALU; regDest = RDST_RA;
        pcWrite = 1'b1; pcSrc = PCSRC_JUMP;
      end
      ST_JR:      begin srcA = 1'b1; aluOp = ALUOPW'(ALU_ADD); pcWrite = 1'b1; pcSrc = PCSRC_ALU; end
      ST_JUMP:    begin pcWrite = 1'b1; pcSrc = PCSRC_JUMP; end
      ST_BEQ, ST_BNE: begin
        srcA = 1'b1; aluOp = ALUOPW'(ALU_SUB); pcWrite = 1'b1; pcSrc = PCSRC_ALU;
        branchCond = (stateReg == ST_BEQ);
      end
      ST_IN: begin
        memtoReg = M2R_IN; regDest = RDST_RD;
        regWrite = bus.InValid; inAck = bus.InValid;
      end
      ST_OUT:     outputWrite = 1'b1;
      default:    ;
    endcase
  end

  // Strobes are suppressed in reset and on the timeout cycle so no partial transfer escapes.
  assign strobeEn        = Reset && !timeout;
  assign bus.ALUOp       = aluOp;
  assign bus.SrcA        = srcA;
  assign bus.SrcB        = srcB;
  assign bus.PCSrc       = pcSrc;
  assign bus.MemtoReg    = memtoReg;
  assign bus.RegDest     = regDest;
  assign bus.MemSrc      = memSrc;
  assign bus.BranchCond  = branchCond;
  assign bus.RegWrite    = regWrite    && strobeEn;
  assign bus.MemRead     = memRead     && strobeEn;
  assign bus.MemWrite    = memWrite    && strobeEn;
  assign bus.IRWrite     = irWrite     && strobeEn;
  assign bus.PCWrite     = pcWrite     && strobeEn;
  assign bus.OutputWrite = outputWrite && strobeEn;
  assign bus.InAck       = inAck       && strobeEn;
  assign bus.MemErr      = Reset && timeout;
  assign bus.current_state = stateReg;
  assign bus.next_state    = stateNext;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegalReg;
  always_ff @(posedge CLK) begin
    if (!Reset)                     illegalReg <= 1'b0;
    else if (stateNext == ST_TRAP)  illegalReg <= 1'b1;
  end
  assign bus.IllegalOp = illegalReg;
`else
  assign bus.IllegalOp = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: directed per-cycle vectors, checked by a negedge monitor.
module tb_multicycle_ctrl_fsm;
  import ctrl_pkg::*;

  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010, A_SUB = 3'b011;

  // Strobe vector order: RegWrite MemRead MemWrite IRWrite PCWrite OutputWrite InAck MemErr IllegalOp
  localparam logic [8:0] S_RW = 9'h100, S_MR = 9'h080, S_MW = 9'h040, S_IRW = 9'h020;
  localparam logic [8:0] S_PCW = 9'h010, S_OW = 9'h008, S_IA = 9'h004, S_ME = 9'h002;
  localparam logic [8:0] S_ILL = 9'h001, S_NONE = 9'h000;
  localparam logic [8:0] S_FETCHOK = S_IRW | S_PCW | S_MR;

  // Mux vector order: ALUOp SrcA SrcB PCSrc MemtoReg RegDest BranchCond
  localparam logic [12:0] MX_NONE  = 13'd0;
  localparam logic [12:0] MX_FETCH = {A_ADD, 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [12:0] MX_DEC   = {A_ADD, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [12:0] MX_ADDR  = {A_ADD, 1'b1, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [12:0] MX_WB    = {3'd0,  1'b0, 2'd0, 2'd0, 2'd1, 2'd1, 1'b0};
  localparam logic [12:0] MX_IN    = {3'd0,  1'b0, 2'd0, 2'd0, 2'd2, 2'd1, 1'b0};
  localparam logic [12:0] MX_BEQ   = {A_SUB, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1};
  localparam logic [12:0] MX_BNE   = {A_SUB, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [12:0] MX_JAL1  = {A_ADD, 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [12:0] MX_JAL2  = {3'd0,  1'b0, 2'd0, 2'd1, 2'd1, 2'd3, 1'b0};
  localparam logic [12:0] MX_JR    = {A_ADD, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [12:0] MX_JUMP  = {3'd0,  1'b0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b0};
  localparam logic [12:0] MX_RT5   = {3'd5,  1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [12:0] MX_ORI   = {A_OR,  1'b1, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0};

  // Handshake input vector order: MemReady InValid OutReady
  localparam logic [2:0] H_0 = 3'b000, H_MR = 3'b100, H_IV = 3'b010, H_OR = 3'b001;

  typedef struct packed {
    logic [4:0]  st;
    logic [8:0]  strb;
    logic [12:0] mux;
  } exp_t;

  logic CLK = 1'b0;
  logic Reset = 1'b0;
  exp_t expQ[$];
  int   assertions = 0;
  int   failures = 0;
  int   txn = 0;

  multicycle_ctrl_fsm_if #(.OPW(4), .FNW(3), .ALUOPW(3)) bus ();

  multicycle_ctrl_fsm #(.OPW(4), .FNW(3), .ALUOPW(3), .MEM_WAIT_MAX(15)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  logic [8:0]  actStrb;
  logic [12:0] actMux;
  assign actStrb = {bus.RegWrite, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.PCWrite,
                    bus.OutputWrite, bus.InAck, bus.MemErr, bus.IllegalOp};
  assign actMux  = {bus.ALUOp, bus.SrcA, bus.SrcB, bus.PCSrc, bus.MemtoReg, bus.RegDest,
                    bus.BranchCond};

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      txn++;
      $display("txn %0d: state=%0d strobes=%h mux=%h", txn, bus.current_state, actStrb, actMux);
      assertions++;
      if (bus.current_state !== e.st) begin
        failures++;
        $display("FAIL state txn %0d: got %0d, expected %0d", txn, bus.current_state, e.st);
      end
      assertions++;
      if (actStrb !== e.strb) begin
        failures++;
        $display("FAIL strobes txn %0d: got %h, expected %h", txn, actStrb, e.strb);
      end
      assertions++;
      if (actMux !== e.mux) begin
        failures++;
        $display("FAIL muxes txn %0d: got %h, expected %h", txn, actMux, e.mux);
      end
    end
  end

  task automatic step(input logic rst, input logic [3:0] op, input logic [2:0] fk,
                      input logic [2:0] hs, input logic [4:0] st, input logic [8:0] strb,
                      input logic [12:0] mx);
    exp_t e;
    Reset        = rst;
    bus.Opcode   = op;
    bus.funk     = fk;
    bus.MemReady = hs[2];
    bus.InValid  = hs[1];
    bus.OutReady = hs[0];
    e.st = st; e.strb = strb; e.mux = mx;
    expQ.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic fetchDecode(input logic [3:0] op, input logic [2:0] fk);
    step(1'b1, op, fk, H_MR, ST_FETCH, S_FETCHOK, MX_FETCH);
    step(1'b1, op, fk, H_0, ST_DECODE, S_NONE, MX_DEC);
  endtask

  initial begin
    bus.Opcode = 4'd0; bus.funk = 3'd0;
    bus.MemReady = 1'b1; bus.InValid = 1'b0; bus.OutReady = 1'b0;
    @(posedge CLK);
    #1;
    // Reset held two cycles, then strobes appear in the release cycle
    step(1'b0, 4'd2, 3'd0, H_MR, ST_FETCH, S_NONE, MX_FETCH);
    step(1'b0, 4'd2, 3'd0, H_MR, ST_FETCH, S_NONE, MX_FETCH);
    step(1'b1, 4'd2, 3'd0, H_MR, ST_FETCH, S_FETCHOK, MX_FETCH);
    // lw with three stalled LWREAD cycles
    step(1'b1, 4'd2, 3'd0, H_0, ST_DECODE, S_NONE, MX_DEC);
    step(1'b1, 4'd2, 3'd0, H_0, ST_ADDR, S_NONE, MX_ADDR);
    for (int i = 0; i < 3; i++) step(1'b1, 4'd2, 3'd0, H_0, ST_LWREAD, S_MR, MX_NONE);
    step(1'b1, 4'd2, 3'd0, H_MR, ST_LWREAD, S_MR, MX_NONE);
    step(1'b1, 4'd2, 3'd0, H_0, ST_LWWB, S_RW, MX_NONE);
    // lw where MemReady arrives exactly on the timeout cycle
    fetchDecode(4'd2, 3'd0);
    step(1'b1, 4'd2, 3'd0, H_0, ST_ADDR, S_NONE, MX_ADDR);
    for (int i = 0; i < 14; i++) step(1'b1, 4'd2, 3'd0, H_0, ST_LWREAD, S_MR, MX_NONE);
    step(1'b1, 4'd2, 3'd0, H_MR, ST_LWREAD, S_MR, MX_NONE);
    step(1'b1, 4'd2, 3'd0, H_0, ST_LWWB, S_RW, MX_NONE);
    // sw that never completes: MemErr on the 15th SWWRITE cycle
    fetchDecode(4'd3, 3'd0);
    step(1'b1, 4'd3, 3'd0, H_0, ST_ADDR, S_NONE, MX_ADDR);
    for (int i = 0; i < 14; i++) step(1'b1, 4'd3, 3'd0, H_0, ST_SWWRITE, S_MW, MX_NONE);
    step(1'b1, 4'd3, 3'd0, H_0, ST_SWWRITE, S_ME, MX_NONE);
    // fetch that never completes
    for (int i = 0; i < 14; i++) step(1'b1, 4'd3, 3'd0, H_0, ST_FETCH, S_MR, MX_FETCH);
    step(1'b1, 4'd3, 3'd0, H_0, ST_FETCH, S_ME, MX_FETCH);
    // reset during SWWRITE with MemReady high: no write strobe
    fetchDecode(4'd3, 3'd0);
    step(1'b1, 4'd3, 3'd0, H_0, ST_ADDR, S_NONE, MX_ADDR);
    step(1'b0, 4'd3, 3'd0, H_MR, ST_SWWRITE, S_NONE, MX_NONE);
    // input port, data after five cycles
    fetchDecode(4'd12, 3'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 4'd12, 3'd1, H_0, ST_IN, S_NONE, MX_IN);
    step(1'b1, 4'd12, 3'd1, H_IV, ST_IN, S_RW | S_IA, MX_IN);
    // output port, accepted immediately
    fetchDecode(4'd12, 3'd0);
    step(1'b1, 4'd12, 3'd0, H_OR, ST_OUT, S_OW, MX_NONE);
    // branches and jumps
    fetchDecode(4'd7, 3'd0);
    step(1'b1, 4'd7, 3'd0, H_0, ST_BEQ, S_PCW, MX_BEQ);
    fetchDecode(4'd8, 3'd0);
    step(1'b1, 4'd8, 3'd0, H_0, ST_BNE, S_PCW, MX_BNE);
    fetchDecode(4'd10, 3'd0);
    step(1'b1, 4'd10, 3'd0, H_0, ST_JAL1, S_NONE, MX_JAL1);
    step(1'b1, 4'd10, 3'd0, H_0, ST_JAL2, S_RW | S_PCW, MX_JAL2);
    fetchDecode(4'd11, 3'd0);
    step(1'b1, 4'd11, 3'd0, H_0, ST_JR, S_PCW, MX_JR);
    fetchDecode(4'd9, 3'd0);
    step(1'b1, 4'd9, 3'd0, H_0, ST_JUMP, S_PCW, MX_JUMP);
    // R-type with funk 5, then ori
    fetchDecode(4'd0, 3'd5);
    step(1'b1, 4'd0, 3'd5, H_0, ST_RTYPE, S_NONE, MX_RT5);
    step(1'b1, 4'd0, 3'd5, H_0, ST_RWRITE, S_RW, MX_WB);
    fetchDecode(4'd4, 3'd0);
    step(1'b1, 4'd4, 3'd0, H_0, ST_IMM, S_NONE, MX_ORI);
    step(1'b1, 4'd4, 3'd0, H_0, ST_IMMWB, S_RW, MX_WB);
    // illegal opcode 6
    fetchDecode(4'd6, 3'd0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) step(1'b1, 4'd6, 3'd0, H_MR, ST_TRAP, S_ILL, MX_NONE);
    step(1'b0, 4'd6, 3'd0, H_MR, ST_TRAP, S_ILL, MX_NONE);
    step(1'b1, 4'd6, 3'd0, H_MR, ST_FETCH, S_FETCHOK, MX_FETCH);
`else
    step(1'b1, 4'd6, 3'd0, H_MR, ST_FETCH, S_FETCHOK, MX_FETCH);
`endif
    @(negedge CLK);
    #1;
    assertions++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
